// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank game control blocks.
package tank_game_pkg;
   typedef enum logic [2:0] {IDLE, SELECT, ANIM, WAIT, CLEAR} spawn_state_e;

   localparam int DEF_NUM_SLOTS  = 4;
   localparam int DEF_NUM_POINTS = 3;
   localparam int CNT_W          = 8;
endpackage

// File: rtl/rr_point_picker.sv
// Combinational round-robin picker: first unblocked index at or after rr_ptr_i, wrapping.
// Zero latency; vld_o low when every point is blocked.
module rr_point_picker import tank_game_pkg::*; #(
   parameter int  NUM_POINTS = DEF_NUM_POINTS,
   localparam int PW         = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
   input  logic [NUM_POINTS-1:0] blocked_i,
   input  logic [PW-1:0]         rr_ptr_i,
   output logic                  vld_o,
   output logic [PW-1:0]         idx_o
);
   logic [PW:0] sum;

   // Scan from the farthest candidate down so the nearest unblocked one wins.
   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      sum   = '0;
      for (int i = NUM_POINTS - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr_i} + (PW + 1)'(i);
         if (sum >= (PW + 1)'(NUM_POINTS)) begin
            sum = sum - (PW + 1)'(NUM_POINTS);
         end
         if (!blocked_i[sum[PW-1:0]]) begin
            vld_o = 1'b1;
            idx_o = sum[PW-1:0];
         end
      end
   end
endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy entry sequencer: owns the reserve pool and slots, spawns into free slot + round-robin point.
// spawn_o and its slot/point are presented in the SELECT cycle that decides the spawn.
module enemy_spawn_scheduler import tank_game_pkg::*; #(
   parameter int  NUM_SLOTS      = DEF_NUM_SLOTS,
   parameter int  NUM_POINTS     = DEF_NUM_POINTS,
   parameter int  TOTAL_ENEMIES  = 20,
   parameter int  SPAWN_INTERVAL = 5000000,
   parameter int  SPAWN_ANIM     = 500000,
   localparam int SW             = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int PW             = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [NUM_SLOTS-1:0]  enemy_die_i,
   input  logic [NUM_POINTS-1:0] point_blocked_i,
   output logic                  spawn_o,
   output logic [SW-1:0]         spawn_slot_o,
   output logic [PW-1:0]         spawn_point_o,
   output logic                  spawning_o,
   output logic [NUM_SLOTS-1:0]  slot_active_o,
   output logic [CNT_W-1:0]      reserve_left_o,
   output logic [CNT_W-1:0]      kills_o,
   output logic                  level_clear_o
);
   localparam logic [31:0] ANIM_LAST = 32'(SPAWN_ANIM - 1);
   localparam logic [31:0] INT_LAST  = 32'(SPAWN_INTERVAL - 1);

   spawn_state_e         state_q, state_d;
   logic [31:0]          anim_tmr_q, anim_tmr_d, int_tmr_q, int_tmr_d;
   logic [PW-1:0]        rr_q, rr_d, point_q, point_d;
   logic [SW-1:0]        slot_q, slot_d;
   logic [NUM_SLOTS-1:0] active_q, active_d;
   logic [CNT_W-1:0]     reserve_q, reserve_d, kills_q, kills_d;

   logic                 pt_vld, slot_vld, spawn;
   logic [PW-1:0]        pt_idx;
   logic [SW-1:0]        free_slot;
   logic [NUM_SLOTS-1:0] kill_mask;
   logic [CNT_W-1:0]     kill_cnt;
   logic [CNT_W:0]       kill_sum;

   rr_point_picker #(.NUM_POINTS(NUM_POINTS)) u_picker (
      .blocked_i (point_blocked_i),
      .rr_ptr_i  (rr_q),
      .vld_o     (pt_vld),
      .idx_o     (pt_idx)
   );

   always_comb begin
      slot_vld  = 1'b0;
      free_slot = '0;
      kill_cnt  = '0;
      kill_mask = enemy_die_i & active_q;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            slot_vld  = 1'b1;
            free_slot = SW'(i);
         end
         kill_cnt = kill_cnt + CNT_W'(kill_mask[i]);
      end
      kill_sum = {1'b0, kills_q} + {1'b0, kill_cnt};
   end

   always_comb begin
      state_d    = state_q;
      anim_tmr_d = anim_tmr_q;
      int_tmr_d  = int_tmr_q;
      rr_d       = rr_q;
      slot_d     = slot_q;
      point_d    = point_q;
      active_d   = active_q;
      reserve_d  = reserve_q;
      kills_d    = kills_q;
      spawn      = 1'b0;
      if (start_i) begin
         state_d    = SELECT;
         anim_tmr_d = '0;
         int_tmr_d  = '0;
         rr_d       = '0;
         active_d   = '0;
         reserve_d  = CNT_W'(TOTAL_ENEMIES);
         kills_d    = '0;
      end else begin
         if (state_q != IDLE) begin
            active_d = active_q & ~kill_mask;
            kills_d  = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
         end
         case (state_q)
            SELECT: begin
               if (reserve_q == '0) begin
                  if (active_q == '0) state_d = CLEAR;
               end else if (slot_vld && pt_vld) begin
                  spawn               = 1'b1;
                  slot_d              = free_slot;
                  point_d             = pt_idx;
                  active_d[free_slot] = 1'b1;
                  reserve_d           = reserve_q - 1'b1;
                  rr_d                = (pt_idx == PW'(NUM_POINTS - 1)) ? '0 : pt_idx + 1'b1;
                  anim_tmr_d          = '0;
                  state_d             = ANIM;
               end
            end
            ANIM: begin
               if (anim_tmr_q == ANIM_LAST) begin
                  anim_tmr_d = '0;
                  int_tmr_d  = '0;
                  // The SELECT cycle itself accounts for one interval cycle.
                  state_d    = (INT_LAST == '0) ? SELECT : WAIT;
               end else begin
                  anim_tmr_d = anim_tmr_q + 32'd1;
               end
            end
            WAIT: begin
               int_tmr_d = int_tmr_q + 32'd1;
               if (int_tmr_d == INT_LAST) state_d = SELECT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         anim_tmr_q <= '0;
         int_tmr_q  <= '0;
         rr_q       <= '0;
         slot_q     <= '0;
         point_q    <= '0;
         active_q   <= '0;
         reserve_q  <= '0;
         kills_q    <= '0;
      end else begin
         state_q    <= state_d;
         anim_tmr_q <= anim_tmr_d;
         int_tmr_q  <= int_tmr_d;
         rr_q       <= rr_d;
         slot_q     <= slot_d;
         point_q    <= point_d;
         active_q   <= active_d;
         reserve_q  <= reserve_d;
         kills_q    <= kills_d;
      end
   end

   assign spawn_o        = spawn;
   assign spawn_slot_o   = spawn ? free_slot : slot_q;
   assign spawn_point_o  = spawn ? pt_idx : point_q;
   assign spawning_o     = (state_q == ANIM);
   assign level_clear_o  = (state_q == CLEAR);
   assign slot_active_o  = active_q;
   assign reserve_left_o = reserve_q;
   assign kills_o        = kills_q;
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler; spawn events are checked by a scoreboard monitor.
module tb_enemy_spawn_scheduler;
   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic [1:0] enemy_die_i;
   logic [2:0] point_blocked_i;
   logic       spawn_o;
   logic [0:0] spawn_slot_o;
   logic [1:0] spawn_point_o;
   logic       spawning_o;
   logic [1:0] slot_active_o;
   logic [7:0] reserve_left_o;
   logic [7:0] kills_o;
   logic       level_clear_o;

   typedef struct {
      int slot;
      int point;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   s;

   enemy_spawn_scheduler #(
      .NUM_SLOTS(2), .NUM_POINTS(3), .TOTAL_ENEMIES(4), .SPAWN_INTERVAL(10), .SPAWN_ANIM(4)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .start_i         (start_i),
      .enemy_die_i     (enemy_die_i),
      .point_blocked_i (point_blocked_i),
      .spawn_o         (spawn_o),
      .spawn_slot_o    (spawn_slot_o),
      .spawn_point_o   (spawn_point_o),
      .spawning_o      (spawning_o),
      .slot_active_o   (slot_active_o),
      .reserve_left_o  (reserve_left_o),
      .kills_o         (kills_o),
      .level_clear_o   (level_clear_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int slot, input int point, input int c);
      exp_t e;
      e.slot  = slot;
      e.point = point;
      e.cyc   = c;
      sb_q.push_back(e);
   endtask

   // Advance to just after the posedge that begins cycle n.
   task automatic at_cyc(input int n);
      if (cyc >= n) begin
         tests++;
         fails++;
         $display("FAIL schedule: at cycle %0d, required before %0d", cyc, n);
      end else begin
         while (cyc < n) begin
            @(posedge clk_i);
            #1;
         end
      end
   endtask

   always @(negedge clk_i) begin
      if (spawn_o) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_spawn: got spawn_o=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("spawn_cycle", cyc, mon_e.cyc);
            chk("spawn_slot", int'(spawn_slot_o), mon_e.slot);
            chk("spawn_point", int'(spawn_point_o), mon_e.point);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; start_i = 1'b0; enemy_die_i = 2'b00; point_blocked_i = 3'b000;
      #2;
      chk("rst_spawn", int'(spawn_o), 0);
      chk("rst_spawning", int'(spawning_o), 0);
      chk("rst_active", int'(slot_active_o), 0);
      chk("rst_reserve", int'(reserve_left_o), 0);
      chk("rst_kills", int'(kills_o), 0);
      chk("rst_clear", int'(level_clear_o), 0);
      chk("rst_slot_point", int'({spawn_slot_o, spawn_point_o}), 0);
      at_cyc(3); reset_i = 1'b0;

      // IDLE ignores kills.
      at_cyc(5); enemy_die_i = 2'b11;
      at_cyc(6); enemy_die_i = 2'b00;
      @(negedge clk_i);
      chk("idle_kills", int'(kills_o), 0);
      chk("idle_spawning", int'(spawning_o), 0);

      // Basic sequence.
      s = 10;
      at_cyc(s); start_i = 1'b1; push(0, 0, s + 1); push(1, 1, s + 15);
      at_cyc(s + 1); start_i = 1'b0;
      @(negedge clk_i); chk("start_reserve", int'(reserve_left_o), 4);
      at_cyc(s + 2); @(negedge clk_i);
      chk("anim_first", int'(spawning_o), 1);
      chk("reserve_after1", int'(reserve_left_o), 3);
      chk("active_after1", int'(slot_active_o), 1);
      at_cyc(s + 5); @(negedge clk_i); chk("anim_last", int'(spawning_o), 1);
      at_cyc(s + 6); @(negedge clk_i); chk("anim_done", int'(spawning_o), 0);
      at_cyc(s + 16); @(negedge clk_i);
      chk("reserve_after2", int'(reserve_left_o), 2);
      chk("active_after2", int'(slot_active_o), 3);

      // Slots full: stall, then kill slot 1 frees it.
      at_cyc(s + 33); @(negedge clk_i);
      chk("full_reserve", int'(reserve_left_o), 2);
      chk("full_spawning", int'(spawning_o), 0);
      at_cyc(s + 35); enemy_die_i = 2'b10; push(1, 2, s + 36);
      at_cyc(s + 36); enemy_die_i = 2'b00;
      @(negedge clk_i); chk("kills_1", int'(kills_o), 1);
      at_cyc(s + 37); @(negedge clk_i);
      chk("reserve_after3", int'(reserve_left_o), 1);
      chk("active_after3", int'(slot_active_o), 3);

      // Kill during ANIM, then all points blocked.
      at_cyc(s + 38); enemy_die_i = 2'b01; point_blocked_i = 3'b111;
      at_cyc(s + 39); enemy_die_i = 2'b00;
      @(negedge clk_i);
      chk("kills_2", int'(kills_o), 2);
      chk("active_kill0", int'(slot_active_o), 2);
      chk("anim_kill_spawning", int'(spawning_o), 1);
      at_cyc(s + 55); @(negedge clk_i);
      chk("blocked_reserve", int'(reserve_left_o), 1);
      chk("blocked_spawning", int'(spawning_o), 0);
      at_cyc(s + 56); point_blocked_i = 3'b011; push(0, 2, s + 56);
      at_cyc(s + 57); @(negedge clk_i);
      chk("reserve_after4", int'(reserve_left_o), 0);
      chk("active_after4", int'(slot_active_o), 3);

      // Simultaneous and spurious kills.
      at_cyc(s + 60); enemy_die_i = 2'b11;
      at_cyc(s + 61); enemy_die_i = 2'b00;
      @(negedge clk_i);
      chk("kills_double", int'(kills_o), 4);
      chk("active_empty", int'(slot_active_o), 0);
      at_cyc(s + 62); enemy_die_i = 2'b01; point_blocked_i = 3'b000;
      at_cyc(s + 63); enemy_die_i = 2'b00;
      @(negedge clk_i); chk("kills_spurious", int'(kills_o), 4);

      // Level clear and restart.
      at_cyc(s + 70); @(negedge clk_i); chk("clear_before", int'(level_clear_o), 0);
      at_cyc(s + 71); @(negedge clk_i); chk("clear_set", int'(level_clear_o), 1);
      at_cyc(s + 75); @(negedge clk_i);
      chk("clear_hold", int'(level_clear_o), 1);
      chk("clear_kills", int'(kills_o), 4);
      at_cyc(s + 76); start_i = 1'b1; push(0, 0, s + 77);
      at_cyc(s + 77); start_i = 1'b0;
      @(negedge clk_i);
      chk("restart_clear", int'(level_clear_o), 0);
      chk("restart_kills", int'(kills_o), 0);
      chk("restart_reserve", int'(reserve_left_o), 4);

      // Asynchronous reset mid-ANIM.
      at_cyc(s + 79);
      chk("pre_reset_spawning", int'(spawning_o), 1);
      reset_i = 1'b1;
      #1;
      chk("arst_spawning", int'(spawning_o), 0);
      chk("arst_active", int'(slot_active_o), 0);
      chk("arst_spawn", int'(spawn_o), 0);
      chk("arst_reserve", int'(reserve_left_o), 0);
      at_cyc(s + 82); reset_i = 1'b0;
      at_cyc(s + 90); @(negedge clk_i);
      chk("post_reset_idle", int'(spawning_o), 0);
      chk("post_reset_reserve", int'(reserve_left_o), 0);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
